l1_refill_arbiter: RTL and testbench
====================================

Name: l1_refill_arbiter

Overview:
- Shares the single L2 line-transfer port between the IL1 refill path and the DL1 refill/writeback path.
- Grants one requester at a time using 2-way round-robin.
- Issues a WRAP burst of LINE_WORDS beats, steers the beats to or from the owner, and signals completion with a one-cycle ack.
- Blocks new grants while an inclusive L2 back-invalidation is in progress.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, beat width
- LINE_WORDS, 8, beats per line burst; power of 2, ≥2

Ports:
- cache_clk  in  1  cache clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- repl_busy  in  1  inclusive back-invalidation active; no new grant while high
- il1_req  in  1  IL1 refill request; held with il1_addr until il1_ack
- il1_addr  in  ADDR_W  IL1 miss address (critical word first)
- il1_rvalid  out  1  refill beat valid to IL1
- il1_rdata  out  DATA_W  refill beat data to IL1
- il1_ack  out  1  one-cycle pulse: IL1 burst complete
- dl1_req  in  1  DL1 request; held with dl1_we/dl1_addr until dl1_ack
- dl1_we  in  1  1 = writeback, 0 = refill
- dl1_addr  in  ADDR_W  DL1 address
- dl1_wdata  in  DATA_W  writeback beat data
- dl1_wready  out  1  writeback beat accepted this cycle
- dl1_rvalid  out  1  refill beat valid to DL1
- dl1_rdata  out  DATA_W  refill beat data to DL1
- dl1_ack  out  1  one-cycle pulse: DL1 burst complete
- l2_req  out  1  burst request to L2
- l2_we  out  1  burst direction
- l2_addr  out  ADDR_W  burst start address
- l2_gnt  in  1  L2 accepts request this cycle
- l2_wdata  out  DATA_W  write beat
- l2_wready  in  1  L2 accepts write beat
- l2_rvalid  in  1  read beat valid
- l2_rdata  in  DATA_W  read beat

Behaviour:

States: ARB, REQ, XFER, ACK.

Registered state: owner (IL1/DL1), we_q, addr_q, beat_cnt[$clog2(LINE_WORDS)-1:0], last_grant.

- Reset (rst high at posedge, including mid-burst):
  - State → ARB, beat_cnt=0, last_grant=DL1 (IL1 wins the first tie).
  - All outputs 0 in the following cycle.
  - An in-flight burst is abandoned; the L2 side is reset by the same rst.
- ARB:
  - If repl_busy, or no req: stay.
  - If only one req is high: grant it.
  - If both are high: grant the one ≠ last_grant.
  - On grant: latch owner, addr_q, we_q (IL1 always read); go to REQ.
  - Grant latency: one cycle from req high to l2_req high.
- REQ:
  - l2_req=1, l2_addr=addr_q, l2_we=we_q.
  - Hold until l2_gnt=1, then XFER with beat_cnt=0.
  - repl_busy going high in REQ does not revoke the grant.
- XFER, read:
  - owner rvalid = l2_rvalid and owner rdata = l2_rdata, combinational, zero added latency.
  - The non-owner rvalid is 0.
  - beat_cnt increments on each l2_rvalid.
  - l2_rvalid with beat_cnt==LINE_WORDS-1 → ACK.
- XFER, write:
  - l2_wdata = dl1_wdata, dl1_wready = l2_wready.
  - Count on l2_wready; the last accepted beat → ACK.
- ACK:
  - The owner's ack=1 for exactly one cycle.
  - last_grant ← owner; next state ARB.
  - Requester must present req=0 in the cycle after ack; a req still high in ARB is treated as a new request.
- l2_rvalid or l2_wready outside XFER is ignored; no beat is forwarded.
- beat_cnt wraps naturally at LINE_WORDS. Address wrap within the line is L2's job; l2_addr is not incremented.
- Minimum burst occupancy: REQ(≥1) + LINE_WORDS + ACK(1) cycles.
- All outputs are driven every cycle: zeros when not owner or not in the relevant state.

Decomposition:
- renas_package gets:
  - l1arb_state_e {ARB, REQ, XFER, ACK}
  - l1arb_owner_e {OWN_IL1, OWN_DL1}
  - default LINE_WORDS tied to ICACHE line size
- One sub-module: rr_arbiter_2. Combinational 2-way round-robin with inputs req[1:0] and last_grant, output a one-hot grant. Reused by future DL1/peripheral sharing.

Test Plan:
1. Reset, then il1_req=1 with il1_addr=0x0000_0104. Expect: l2_req next cycle with l2_addr=0x104, l2_we=0. After l2_gnt, 8 l2_rvalid beats appear on il1_rvalid/rdata, and il1_ack pulses once in the cycle after beat 8.
2. il1_req and dl1_req rise in the same cycle, repeated for 3 back-to-back bursts. Expect grant order IL1, DL1, IL1, and dl1_rvalid=0 throughout every IL1 burst.
3. DL1 writeback with dl1_we=1 and dl1_wdata=0xA5A5_0000+beat, while l2_wready toggles 1,0,1… Expect dl1_wready to mirror l2_wready, 8 accepted beats, then dl1_ack.
4. repl_busy=1 with il1_req=1 for 10 cycles: l2_req stays 0. repl_busy drops: l2_req=1 the next cycle. repl_busy rising during REQ: the burst still completes.
5. Assert rst after beat 3 of an IL1 refill. Expect: state ARB, all outputs 0 next cycle. A following dl1_req refill completes normally with beat_cnt starting at 0.
6. Stray l2_rvalid pulses in ARB and REQ. Expect no il1_rvalid/dl1_rvalid, and the beat count of the later burst unaffected.

Source files
------------

// File: rtl/l1_refill_arbiter_pkg.sv
// Shared types and constants for the L1 refill arbiter slice.
// Declares the FSM state encodings, the requester identities and the default burst length.
package l1_refill_arbiter_pkg;

    // Default burst length matches the ICACHE line size in words
    localparam int unsigned ICACHE_LINE_WORDS = 8;

    typedef logic [1:0] l1arb_state_e;

    localparam l1arb_state_e ST_ARB  = 2'd0;
    localparam l1arb_state_e ST_REQ  = 2'd1;
    localparam l1arb_state_e ST_XFER = 2'd2;
    localparam l1arb_state_e ST_ACK  = 2'd3;

    typedef enum logic {
        OWN_IL1 = 1'b0,
        OWN_DL1 = 1'b1
    } l1arb_owner_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational round-robin arbiter.
// Bit 0 is IL1 and bit 1 is DL1. A tie goes to the requester that was not granted last.
module rr_arbiter_2
    import l1_refill_arbiter_pkg::*;
(
    input  logic [1:0]   req,
    input  l1arb_owner_e last_grant,
    output logic [1:0]   grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_DL1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Shares the L2 line-transfer port between the IL1 refill path and the DL1 refill/writeback path.
// Issues one wrap burst per grant, steers beats to or from the owner, and pulses that owner's ack on completion.
module l1_refill_arbiter
    import l1_refill_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic              cache_clk,
    input  logic              rst,
    input  logic              repl_busy,

    input  logic              il1_req,
    input  logic [ADDR_W-1:0] il1_addr,
    output logic              il1_rvalid,
    output logic [DATA_W-1:0] il1_rdata,
    output logic              il1_ack,

    input  logic              dl1_req,
    input  logic              dl1_we,
    input  logic [ADDR_W-1:0] dl1_addr,
    input  logic [DATA_W-1:0] dl1_wdata,
    output logic              dl1_wready,
    output logic              dl1_rvalid,
    output logic [DATA_W-1:0] dl1_rdata,
    output logic              dl1_ack,

    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_gnt,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic              l2_wready,
    input  logic              l2_rvalid,
    input  logic [DATA_W-1:0] l2_rdata
);

    localparam int unsigned CNT_W = $clog2(LINE_WORDS);

    l1arb_state_e r_state;
    l1arb_state_e w_state_nxt;
    l1arb_owner_e r_owner;
    l1arb_owner_e w_owner_nxt;
    l1arb_owner_e r_last_grant;
    l1arb_owner_e w_last_grant_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_nxt;

    logic [1:0] w_gnt;
    logic       w_beat;
    logic       w_last_beat;

    rr_arbiter_2 u_rr (
        .req        ({dl1_req, il1_req}),
        .last_grant (r_last_grant),
        .grant      (w_gnt)
    );

    // A beat is the L2 handshake matching the burst direction; only meaningful in XFER
    assign w_beat      = (r_state == ST_XFER) && (r_we ? l2_wready : l2_rvalid);
    assign w_last_beat = w_beat && (r_beat_cnt == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge cache_clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_owner      <= OWN_IL1;
            r_last_grant <= OWN_DL1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    // Next-state and grant latching
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_we_nxt         = r_we;
        w_addr_nxt       = r_addr;
        w_beat_cnt_nxt   = r_beat_cnt;

        case (r_state)
            ST_ARB: begin
                if (!repl_busy && (w_gnt != 2'b00)) begin
                    w_state_nxt = ST_REQ;
                    if (w_gnt[1]) begin
                        w_owner_nxt = OWN_DL1;
                        w_addr_nxt  = dl1_addr;
                        w_we_nxt    = dl1_we;
                    end else begin
                        w_owner_nxt = OWN_IL1;
                        w_addr_nxt  = il1_addr;
                        w_we_nxt    = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (l2_gnt) begin
                    w_state_nxt    = ST_XFER;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_XFER: begin
                if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
                if (w_last_beat) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_last_grant_nxt = r_owner;
                w_state_nxt      = ST_ARB;
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Output steering; read beats pass straight through with no added latency
    always_comb begin
        il1_rvalid = 1'b0;
        il1_rdata  = '0;
        il1_ack    = 1'b0;
        dl1_wready = 1'b0;
        dl1_rvalid = 1'b0;
        dl1_rdata  = '0;
        dl1_ack    = 1'b0;
        l2_req     = 1'b0;
        l2_we      = 1'b0;
        l2_addr    = '0;
        l2_wdata   = '0;

        case (r_state)
            ST_REQ: begin
                l2_req  = 1'b1;
                l2_we   = r_we;
                l2_addr = r_addr;
            end
            ST_XFER: begin
                if (r_we) begin
                    if (r_owner == OWN_DL1) begin
                        l2_wdata   = dl1_wdata;
                        dl1_wready = l2_wready;
                    end
                end else if (r_owner == OWN_IL1) begin
                    il1_rvalid = l2_rvalid;
                    il1_rdata  = l2_rdata;
                end else begin
                    dl1_rvalid = l2_rvalid;
                    dl1_rdata  = l2_rdata;
                end
            end
            ST_ACK: begin
                if (r_owner == OWN_IL1) begin
                    il1_ack = 1'b1;
                end else begin
                    dl1_ack = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Scoreboard bench for l1_refill_arbiter.
// Stimulus pushes expected events; a negedge monitor pops and compares each observed DUT event.
module tb_l1_refill_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    localparam logic [2:0] EV_REQR = 3'd0;
    localparam logic [2:0] EV_REQW = 3'd1;
    localparam logic [2:0] EV_IL1B = 3'd2;
    localparam logic [2:0] EV_DL1B = 3'd3;
    localparam logic [2:0] EV_WB   = 3'd4;
    localparam logic [2:0] EV_IACK = 3'd5;
    localparam logic [2:0] EV_DACK = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } ev_t;

    logic          cache_clk = 1'b0;
    logic          rst;
    logic          repl_busy;
    logic          il1_req;
    logic [AW-1:0] il1_addr;
    logic          il1_rvalid;
    logic [DW-1:0] il1_rdata;
    logic          il1_ack;
    logic          dl1_req;
    logic          dl1_we;
    logic [AW-1:0] dl1_addr;
    logic [DW-1:0] dl1_wdata;
    logic          dl1_wready;
    logic          dl1_rvalid;
    logic [DW-1:0] dl1_rdata;
    logic          dl1_ack;
    logic          l2_req;
    logic          l2_we;
    logic [AW-1:0] l2_addr;
    logic          l2_gnt;
    logic [DW-1:0] l2_wdata;
    logic          l2_wready;
    logic          l2_rvalid;
    logic [DW-1:0] l2_rdata;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic prev_req = 1'b0;

    always #5 cache_clk = ~cache_clk;

    l1_refill_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LINE_WORDS (LW)
    ) dut (
        .cache_clk  (cache_clk),
        .rst        (rst),
        .repl_busy  (repl_busy),
        .il1_req    (il1_req),
        .il1_addr   (il1_addr),
        .il1_rvalid (il1_rvalid),
        .il1_rdata  (il1_rdata),
        .il1_ack    (il1_ack),
        .dl1_req    (dl1_req),
        .dl1_we     (dl1_we),
        .dl1_addr   (dl1_addr),
        .dl1_wdata  (dl1_wdata),
        .dl1_wready (dl1_wready),
        .dl1_rvalid (dl1_rvalid),
        .dl1_rdata  (dl1_rdata),
        .dl1_ack    (dl1_ack),
        .l2_req     (l2_req),
        .l2_we      (l2_we),
        .l2_addr    (l2_addr),
        .l2_gnt     (l2_gnt),
        .l2_wdata   (l2_wdata),
        .l2_wready  (l2_wready),
        .l2_rvalid  (l2_rvalid),
        .l2_rdata   (l2_rdata)
    );

    task automatic observe(input logic [2:0] kind, input logic [31:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %h, required no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %h, required kind %0d data %h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every DUT-presented event is compared against the scoreboard
    always @(negedge cache_clk) begin
        if (mon_en) begin
            if (l2_req && !prev_req) observe(l2_we ? EV_REQW : EV_REQR, l2_addr);
            if (il1_rvalid)          observe(EV_IL1B, il1_rdata);
            if (dl1_rvalid)          observe(EV_DL1B, dl1_rdata);
            if (dl1_wready)          observe(EV_WB, l2_wdata);
            if (il1_ack)             observe(EV_IACK, 32'h0);
            if (dl1_ack)             observe(EV_DACK, 32'h0);
        end
        prev_req = l2_req;
    end

    task automatic tick();
        @(posedge cache_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic chk_idle(input string name);
        n_checks++;
        if ((|{il1_rvalid, il1_rdata, il1_ack, dl1_wready, dl1_rvalid, dl1_rdata, dl1_ack,
               l2_req, l2_we, l2_addr, l2_wdata}) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got l2_req=%b l2_addr=%h il1_rvalid=%b dl1_rvalid=%b acks=%b%b, required all zero",
                     name, l2_req, l2_addr, il1_rvalid, dl1_rvalid, il1_ack, dl1_ack);
        end
    endtask

    function automatic void push(input logic [2:0] kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_read(input bit is_dl1, input logic [31:0] addr, input logic [31:0] base);
        push(EV_REQR, addr);
        for (int i = 0; i < int'(LW); i++) push(is_dl1 ? EV_DL1B : EV_IL1B, base + 32'(i));
        push(is_dl1 ? EV_DACK : EV_IACK, 32'h0);
    endfunction

    task automatic l2_grant();
        int t = 0;
        while (!l2_req && t < 50) begin
            tick();
            t++;
        end
        chk("l2_req_wait", 32'(l2_req), 32'd1);
        l2_gnt = 1'b1;
        tick();
        l2_gnt = 1'b0;
    endtask

    task automatic l2_read(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            l2_rvalid = 1'b1;
            l2_rdata  = base + 32'(i);
            tick();
        end
        l2_rvalid = 1'b0;
        l2_rdata  = '0;
    endtask

    task automatic l2_write(input logic [31:0] base);
        int k = 0;
        int c = 0;
        while (k < int'(LW) && c < 40) begin
            l2_wready = (c % 2 == 0);
            dl1_wdata = base + 32'(k);
            @(negedge cache_clk);
            chk("dl1_wready_mirror", 32'(dl1_wready), 32'(l2_wready));
            tick();
            if (l2_wready) k++;
            c++;
        end
        l2_wready = 1'b0;
    endtask

    task automatic wait_ack(input bit is_dl1);
        int t = 0;
        while (!(is_dl1 ? dl1_ack : il1_ack) && t < 50) begin
            tick();
            t++;
        end
        chk(is_dl1 ? "dl1_ack_wait" : "il1_ack_wait", 32'(is_dl1 ? dl1_ack : il1_ack), 32'd1);
        if (is_dl1) dl1_req = 1'b0;
        else        il1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; repl_busy = 1'b0;
        il1_req = 1'b0; il1_addr = '0;
        dl1_req = 1'b0; dl1_we = 1'b0; dl1_addr = '0; dl1_wdata = '0;
        l2_gnt = 1'b0; l2_wready = 1'b0; l2_rvalid = 1'b0; l2_rdata = '0;
        repeat (3) tick();
        chk_idle("reset_idle");
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Basic IL1 refill with one-cycle grant latency
        exp_read(1'b0, 32'h0000_0104, 32'hC000_0000);
        il1_req = 1'b1; il1_addr = 32'h0000_0104;
        tick();
        chk("grant_latency_l2_req", 32'(l2_req), 32'd1);
        chk("l2_addr", l2_addr, 32'h0000_0104);
        chk("l2_we_il1", 32'(l2_we), 32'd0);
        l2_grant();
        l2_read(32'hC000_0000, LW);
        chk("il1_ack_after_beat8", 32'(il1_ack), 32'd1);
        wait_ack(1'b0);
        tick();

        // DL1 writeback with toggling l2_wready
        push(EV_REQW, 32'h0000_0500);
        for (int i = 0; i < int'(LW); i++) push(EV_WB, 32'hA5A5_0000 + 32'(i));
        push(EV_DACK, 32'h0);
        dl1_req = 1'b1; dl1_we = 1'b1; dl1_addr = 32'h0000_0500;
        l2_grant();
        l2_write(32'hA5A5_0000);
        wait_ack(1'b1);
        dl1_we = 1'b0;
        tick();

        // Simultaneous requests: round-robin order IL1, DL1, IL1, DL1
        exp_read(1'b0, 32'h0000_0200, 32'h0000_1000);
        exp_read(1'b1, 32'h0000_0300, 32'h0000_2000);
        exp_read(1'b0, 32'h0000_0400, 32'h0000_3000);
        exp_read(1'b1, 32'h0000_0300, 32'h0000_4000);
        il1_req = 1'b1; il1_addr = 32'h0000_0200;
        dl1_req = 1'b1; dl1_we = 1'b0; dl1_addr = 32'h0000_0300;
        l2_grant();
        l2_read(32'h0000_1000, LW);
        wait_ack(1'b0);
        tick();
        il1_req = 1'b1; il1_addr = 32'h0000_0400;
        l2_grant();
        l2_read(32'h0000_2000, LW);
        wait_ack(1'b1);
        tick();
        dl1_req = 1'b1;
        l2_grant();
        l2_read(32'h0000_3000, LW);
        wait_ack(1'b0);
        l2_grant();
        l2_read(32'h0000_4000, LW);
        wait_ack(1'b1);
        tick();

        // Back-invalidation blocks grants but does not revoke one already in REQ
        exp_read(1'b0, 32'h0000_0600, 32'h0000_6000);
        repl_busy = 1'b1;
        il1_req = 1'b1; il1_addr = 32'h0000_0600;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_blocks_l2_req", 32'(l2_req), 32'd0);
        end
        repl_busy = 1'b0;
        tick();
        chk("busy_release_l2_req", 32'(l2_req), 32'd1);
        repl_busy = 1'b1;
        tick();
        chk("req_held_under_busy", 32'(l2_req), 32'd1);
        l2_gnt = 1'b1;
        tick();
        l2_gnt = 1'b0;
        l2_read(32'h0000_6000, LW);
        wait_ack(1'b0);
        repl_busy = 1'b0;
        tick();

        // Reset after the third beat of an IL1 refill, then a clean DL1 refill
        push(EV_REQR, 32'h0000_0700);
        for (int i = 0; i < 3; i++) push(EV_IL1B, 32'h0000_7000 + 32'(i));
        il1_req = 1'b1; il1_addr = 32'h0000_0700;
        l2_grant();
        l2_read(32'h0000_7000, 3);
        rst = 1'b1;
        il1_req = 1'b0;
        tick();
        rst = 1'b0;
        l2_rvalid = 1'b1; l2_rdata = 32'hDEAD_BEEF;
        @(negedge cache_clk);
        chk_idle("post_reset_idle");
        tick();
        l2_rvalid = 1'b0; l2_rdata = '0;
        exp_read(1'b1, 32'h0000_0800, 32'h0000_8000);
        dl1_req = 1'b1; dl1_we = 1'b0; dl1_addr = 32'h0000_0800;
        l2_grant();
        l2_read(32'h0000_8000, LW);
        wait_ack(1'b1);
        tick();

        // Stray L2 strobes in ARB and REQ must be ignored
        l2_rvalid = 1'b1; l2_wready = 1'b1; l2_rdata = 32'hBAD0_0000;
        tick();
        tick();
        l2_rvalid = 1'b0; l2_wready = 1'b0;
        exp_read(1'b0, 32'h0000_0900, 32'h0000_9000);
        il1_req = 1'b1; il1_addr = 32'h0000_0900;
        tick();
        l2_rvalid = 1'b1;
        tick();
        tick();
        l2_rvalid = 1'b0;
        l2_gnt = 1'b1;
        tick();
        l2_gnt = 1'b0;
        l2_read(32'h0000_9000, LW);
        wait_ack(1'b0);
        repeat (4) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
